// File: rtl/cardinal_pkg.sv
// cardinal_pkg: shared constants for the cardinal NIC (word width, VC tag bit, register map)
package cardinal_pkg;
   localparam int DATA_WIDTH = 64;
   localparam int VC_BIT = 0;
   localparam logic [1:0] IBUF = 2'b00, ISTAT = 2'b01, OBUF = 2'b10, OSTAT = 2'b11;
endpackage

// File: rtl/cardinal_nic_if.sv
// cardinal_nic_if: processor register port plus router input/output channels of the NIC
// processor: addr, d_in, d_out, nicEn, nicWrEn
// router in: net_si (valid), net_ri (ready), net_di (data)
// router out: net_so (valid), net_ro (ready), net_do (data), net_polarity
interface cardinal_nic_if #(parameter int DATA_WIDTH = cardinal_pkg::DATA_WIDTH);
   logic [1:0] addr;
   logic [DATA_WIDTH-1:0] d_in, d_out;
   logic nicEn, nicWrEn;
   logic net_si, net_ri;
   logic [DATA_WIDTH-1:0] net_di;
   logic net_so, net_ro;
   logic [DATA_WIDTH-1:0] net_do;
   logic net_polarity;
   modport master (
      output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
      input d_out, net_ri, net_so, net_do
   );
   modport slave (
      input addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
      output d_out, net_ri, net_so, net_do
   );
endinterface

// File: rtl/nic_channel_buffer.sv
// nic_channel_buffer: single-entry data register with full flag
// set loads d and marks full; clr drops full and keeps q; reset clears both
module nic_channel_buffer #(parameter int W = 64) (
   input  logic         clk,
   input  logic         reset,
   input  logic         set,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         full
);
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
         full <= 1'b0;
      end else if (set) begin
         q <= d;
         full <= 1'b1;
      end else if (clr)
         full <= 1'b0;
   end
endmodule

// File: rtl/cardinal_nic.sv
// cardinal_nic: memory-mapped NIC joining a processor to a router through one input and one output buffer
// ports: clk, reset (sync, active high), bus (cardinal_nic_if.slave: processor registers and router channels)
module cardinal_nic import cardinal_pkg::*; #(
   parameter int DATA_WIDTH = cardinal_pkg::DATA_WIDTH,
   parameter int VC_BIT = cardinal_pkg::VC_BIT
) (
   input logic clk,
   input logic reset,
   cardinal_nic_if.slave bus
);
   logic [DATA_WIDTH-1:0] ibuf_q, obuf_q;
   logic ibuf_full, obuf_full;
   logic ibuf_set, ibuf_clr, obuf_set;
   logic rd, wr;
   assign rd = bus.nicEn & ~bus.nicWrEn;
   assign wr = bus.nicEn & bus.nicWrEn;
   // set requires empty and clear requires full, so the strobes of one buffer never coincide
   assign ibuf_set = bus.net_si & bus.net_ri;
   assign ibuf_clr = rd & (bus.addr == IBUF) & ibuf_full;
   assign obuf_set = wr & (bus.addr == OBUF) & ~obuf_full;
   assign bus.net_ri = ~ibuf_full & ~reset;
   // packets use [0:63] numbering, so tag bit VC_BIT sits at index DATA_WIDTH-1-VC_BIT here
   assign bus.net_so = obuf_full & bus.net_ro & (obuf_q[DATA_WIDTH-1-VC_BIT] != bus.net_polarity) & ~reset;
   assign bus.net_do = obuf_q;
   // status flag is bit DATA_WIDTH-1 in [0:63] numbering, i.e. the LSB of this vector
   assign bus.d_out = (bus.addr == IBUF) ? ibuf_q :
                      (bus.addr == ISTAT) ? {{(DATA_WIDTH-1){1'b0}}, ibuf_full} :
                      (bus.addr == OSTAT) ? {{(DATA_WIDTH-1){1'b0}}, obuf_full} : '0;
   nic_channel_buffer #(.W(DATA_WIDTH)) u_ibuf (
      .clk(clk), .reset(reset), .set(ibuf_set), .clr(ibuf_clr), .d(bus.net_di), .q(ibuf_q), .full(ibuf_full)
   );
   nic_channel_buffer #(.W(DATA_WIDTH)) u_obuf (
      .clk(clk), .reset(reset), .set(obuf_set), .clr(bus.net_so), .d(bus.d_in), .q(obuf_q), .full(obuf_full)
   );
endmodule

// File: tb/tb_cardinal_nic.sv
// tb_cardinal_nic: directed vector table plus reset sequences for cardinal_nic
module tb_cardinal_nic;
   localparam logic [63:0] P1 = 64'h8000_0000_0000_0042;
   localparam logic [63:0] P2 = 64'h8000_0000_0000_0055;
   typedef struct {
      logic en, wr;
      logic [1:0] addr;
      logic [63:0] din;
      logic si;
      logic [63:0] di;
      logic ro, pol;
      logic ri, so;
      logic [63:0] dout, ndo;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   int checks = 0, errors = 0;
   vec_t v[26];
   always #5 clk = ~clk;
   cardinal_nic_if #(.DATA_WIDTH(64)) bus ();
   cardinal_nic #(.DATA_WIDTH(64), .VC_BIT(0)) dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, wr, input logic [1:0] addr, input logic [63:0] din,
                        input logic si, input logic [63:0] di, input logic ro, pol);
      bus.nicEn = en;
      bus.nicWrEn = wr;
      bus.addr = addr;
      bus.d_in = din;
      bus.net_si = si;
      bus.net_di = di;
      bus.net_ro = ro;
      bus.net_polarity = pol;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      v[0]  = '{1,0,2'd1,0,0,0,0,0, 1,0,64'h0,64'h0};
      v[1]  = '{1,0,2'd3,0,0,0,0,0, 1,0,64'h0,64'h0};
      v[2]  = '{0,0,2'd0,0,1,64'hA5,0,0, 1,0,64'h0,64'h0};
      v[3]  = '{1,0,2'd1,0,0,0,0,0, 0,0,64'h1,64'h0};
      v[4]  = '{1,0,2'd0,0,0,0,0,0, 0,0,64'hA5,64'h0};
      v[5]  = '{1,0,2'd0,0,0,0,0,0, 1,0,64'hA5,64'h0};
      v[6]  = '{0,0,2'd0,0,1,64'hBB,0,0, 1,0,64'hA5,64'h0};
      v[7]  = '{0,0,2'd0,0,1,64'hCC,0,0, 0,0,64'hBB,64'h0};
      v[8]  = '{1,0,2'd0,0,1,64'hDD,0,0, 0,0,64'hBB,64'h0};
      v[9]  = '{1,0,2'd1,0,0,0,0,0, 1,0,64'h0,64'h0};
      v[10] = '{1,1,2'd2,P1,0,0,1,0, 1,0,64'h0,64'h0};
      v[11] = '{1,0,2'd3,0,0,0,1,0, 1,1,64'h1,P1};
      v[12] = '{1,0,2'd3,0,0,0,1,0, 1,0,64'h0,P1};
      v[13] = '{1,1,2'd2,P1,0,0,1,1, 1,0,64'h0,P1};
      v[14] = '{1,0,2'd3,0,0,0,1,1, 1,0,64'h1,P1};
      v[15] = '{1,0,2'd3,0,0,0,1,0, 1,1,64'h1,P1};
      v[16] = '{1,0,2'd3,0,0,0,1,0, 1,0,64'h0,P1};
      v[17] = '{1,1,2'd2,P2,0,0,0,0, 1,0,64'h0,P1};
      v[18] = '{1,0,2'd3,0,0,0,0,0, 1,0,64'h1,P2};
      v[19] = '{1,1,2'd2,64'h7,0,0,1,0, 1,1,64'h0,P2};
      v[20] = '{1,0,2'd3,0,0,0,1,0, 1,0,64'h0,P2};
      v[21] = '{1,1,2'd0,64'hFF,0,0,0,0, 1,0,64'hBB,P2};
      v[22] = '{1,1,2'd3,64'hFF,0,0,0,0, 1,0,64'h0,P2};
      v[23] = '{0,0,2'd0,0,0,0,0,0, 1,0,64'hBB,P2};
      v[24] = '{0,1,2'd2,64'h9,0,0,0,0, 1,0,64'h0,P2};
      v[25] = '{1,0,2'd3,0,0,0,0,0, 1,0,64'h0,P2};

      reset = 1'b1;
      drive(0, 0, 2'd1, 0, 0, 0, 0, 0);
      tick();
      chk("rst.ri", 64'(bus.net_ri), 64'h0);
      chk("rst.so", 64'(bus.net_so), 64'h0);
      tick();
      reset = 1'b0;
      #1;
      chk("idle.ri", 64'(bus.net_ri), 64'h1);
      chk("idle.so", 64'(bus.net_so), 64'h0);
      chk("idle.do", bus.net_do, 64'h0);
      chk("idle.istat", bus.d_out, 64'h0);

      for (int i = 0; i < 26; i++) begin
         drive(v[i].en, v[i].wr, v[i].addr, v[i].din, v[i].si, v[i].di, v[i].ro, v[i].pol);
         #1;
         chk($sformatf("v%0d.ri", i), 64'(bus.net_ri), 64'(v[i].ri));
         chk($sformatf("v%0d.so", i), 64'(bus.net_so), 64'(v[i].so));
         chk($sformatf("v%0d.dout", i), bus.d_out, v[i].dout);
         chk($sformatf("v%0d.ndo", i), bus.net_do, v[i].ndo);
         tick();
      end

      // fill both buffers, then reset mid-transfer
      drive(1, 1, 2'd2, 64'h8000_0000_0000_0099, 1, 64'h77, 0, 0);
      tick();
      drive(0, 0, 2'd1, 0, 0, 0, 1, 0);
      #1;
      chk("mid.so_ready", 64'(bus.net_so), 64'h1);
      chk("mid.istat", bus.d_out, 64'h1);
      reset = 1'b1;
      #1;
      chk("mid.rst_so", 64'(bus.net_so), 64'h0);
      chk("mid.rst_ri", 64'(bus.net_ri), 64'h0);
      tick();
      reset = 1'b0;
      #1;
      chk("post.ri", 64'(bus.net_ri), 64'h1);
      chk("post.so", 64'(bus.net_so), 64'h0);
      chk("post.do", bus.net_do, 64'h0);
      chk("post.istat", bus.d_out, 64'h0);
      bus.addr = 2'd3;
      #1;
      chk("post.ostat", bus.d_out, 64'h0);
      bus.addr = 2'd0;
      #1;
      chk("post.ibuf", bus.d_out, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cardinal_nic.md
CARDINAL_NIC -- requirements
Module: cardinal_nic

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the width of the processor and network data words.
REQ-002 SHALL have parameter VC_BIT, default 0, meaning the packet bit index carrying the virtual-channel tag (bit 0 is the MSB, [0:63] numbering).
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port addr, input, 2, register select from the processor.
REQ-006 SHALL have port d_in, input, DATA_WIDTH, processor store data.
REQ-007 SHALL have port d_out, output, DATA_WIDTH, data returned to the processor.
REQ-008 SHALL have port nicEn, input, 1, access enable.
REQ-009 SHALL have port nicWrEn, input, 1, write (1) / read (0) qualifier.
REQ-010 SHALL have ports net_si (in, 1, router valid), net_ri (out, 1, NIC ready) and net_di (in, DATA_WIDTH, router data) for the input channel.
REQ-011 SHALL have ports net_so (out, 1, NIC valid), net_ro (in, 1, router ready) and net_do (out, DATA_WIDTH, NIC data) for the output channel.
REQ-012 SHALL have port net_polarity, input, 1, router even/odd cycle polarity.

Function
REQ-013 SHALL decode addr as follows: 00 = input channel buffer (read); 01 = input status (read); 10 = output channel buffer (write); 11 = output status (read).
REQ-014 SHALL drive d_out combinationally in the same cycle as a read, with no latency.
REQ-015 SHALL drive d_out with the following values by addr: 00 gives the input buffer contents; 01 and 11 give zeros with bit DATA_WIDTH-1 equal to the ibuf_full or obuf_full flag; 10 gives zero.
REQ-016 SHALL, at a clock edge where nicEn=1, nicWrEn=0, addr=00 and ibuf_full=1, clear ibuf_full; the data register is unchanged.
REQ-017 SHALL treat a read of addr 00 while ibuf_full=0 as returning stale buffer data with no state change.
REQ-018 SHALL drive net_ri = ~ibuf_full & ~reset.
REQ-019 SHALL, at a clock edge where net_si=1 and net_ri=1, capture net_di into the input buffer and set ibuf_full.
REQ-020 SHALL, at a clock edge where nicEn=1, nicWrEn=1, addr=10 and obuf_full=0, capture d_in into the output buffer and set obuf_full.
REQ-021 SHALL drop a processor write issued while obuf_full=1 (sampled before the edge), even if a send completes in that same cycle; software polls addr 11.
REQ-022 SHALL ignore writes to addr 00, 01 and 11, and reads of addr 10.
REQ-023 SHALL drive net_do with the output buffer contents at all times.
REQ-024 SHALL drive net_so = obuf_full & net_ro & (obuf[VC_BIT] != net_polarity) & ~reset.
REQ-025 SHALL clear obuf_full at every clock edge where net_so=1 (one packet per handshake, single-cycle transfer).
REQ-026 SHALL, when processor read-clear and router capture coincide, behave per the flags sampled before the edge; net_ri=0 while full prevents any overwrite.
REQ-027 SHALL give nicEn=0 priority over every other processor input: no state change from processor ports.

Reset
REQ-028 SHALL, on a reset edge, clear both buffers to 0 and clear both full flags; net_so=0, net_ri=0 and d_out follows the decode of the cleared state while reset is high.
REQ-029 SHALL, on reset mid-transfer, discard any pending packet in either buffer; no handshake completes in the reset cycle.

Structure
REQ-030 SHALL place the address constants (IBUF, ISTAT, OBUF, OSTAT), DATA_WIDTH and VC_BIT in a shared package cardinal_pkg.
REQ-031 SHALL implement one sub-module nic_channel_buffer (a single-entry data register plus full flag with set/clear strobes), instantiated twice (input and output).

Verification
REQ-032 SHALL cover reset then idle: net_ri=1, net_so=0, and reads of 01/11 return 0.
REQ-033 SHALL cover input: net_si=1, net_di=64'hA5 -> next cycle net_ri=0 and read 01 returns 64'h1; read 00 returns 64'hA5; after the read edge net_ri=1.
REQ-034 SHALL cover output: write 10 with 64'h8000_0000_0000_0042, net_ro=1, net_polarity=0 -> net_so=1 in the next cycle with net_do=that value, and obuf_full then clears.
REQ-035 SHALL cover polarity blocking: same packet, net_polarity=1 -> net_so stays 0; toggle polarity to 0 -> send completes.
REQ-036 SHALL cover a full-buffer write drop: second write 64'h7 while obuf_full=1 -> the sent packet is the first value and 64'h7 is never seen on net_do.
REQ-037 SHALL cover back-pressure: net_si held 1 with a new net_di while ibuf_full=1 -> the buffer holds the old value until it is read.
